// File: rtl/dtn_arbiter.sv
// Round-robin arbiter feeding one DTN injection port through a single registered slot.
// Messages addressed to the all-ones destination are acked and dropped.
module dtn_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_SOURCES-1:0]           src_valid,
  input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] src_from,
  input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] src_to,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SOURCES-1:0]           src_ack,
  output logic                             dtn_valid,
  output logic [ADDR_WIDTH-1:0]            dtn_from,
  output logic [ADDR_WIDTH-1:0]            dtn_to,
  output logic [DATA_WIDTH-1:0]            dtn_data,
  input  logic                             dtn_ack,
  output logic [COUNT_WIDTH-1:0]           fwd_count
);

  // state | meaning
  // EMPTY | output slot holds no message
  // FULL  | output slot holds a message waiting for dtn_ack
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam int IDX_W = $clog2(NUM_SOURCES);

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0]  from_q, from_d;
  logic [ADDR_WIDTH-1:0]  to_q, to_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                   can_accept;
  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0]  sel_from;
  logic [ADDR_WIDTH-1:0]  sel_to;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   grant;
  logic                   fwd_grant;
  int                     cand;

  assign can_accept = (state_q == EMPTY) || dtn_ack;

  // First valid source after last_q, wrapping; the flag keeps the earliest hit.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_from    = '0;
    sel_to      = '0;
    sel_data    = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      cand = (int'(last_q) + k) % NUM_SOURCES;
      if (!grant_found && src_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
        sel_from    = src_from[cand*ADDR_WIDTH +: ADDR_WIDTH];
        sel_to      = src_to[cand*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data    = src_data[cand*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Inputs are ignored while reset is held so no ack escapes during reset.
  assign grant     = reset_n && grant_found && can_accept;
  assign fwd_grant = grant && !(&sel_to);

  always_comb begin
    src_ack = '0;
    if (grant) begin
      src_ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    from_d  = from_q;
    to_d    = to_q;
    data_d  = data_q;
    count_d = count_q;
    if (grant) begin
      last_d = grant_idx;
    end
    if (fwd_grant) begin
      state_d = FULL;
      from_d  = sel_from;
      to_d    = sel_to;
      data_d  = sel_data;
    end else if ((state_q == FULL) && dtn_ack) begin
      state_d = EMPTY;
    end
    if ((state_q == FULL) && dtn_ack) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      last_q  <= IDX_W'(NUM_SOURCES - 1);
      from_q  <= '0;
      to_q    <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      from_q  <= from_d;
      to_q    <= to_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign dtn_valid = (state_q == FULL);
  assign dtn_from  = from_q;
  assign dtn_to    = to_q;
  assign dtn_data  = data_q;
  assign fwd_count = count_q;

endmodule

// File: tb/tb_dtn_arbiter.sv
// Directed bench for dtn_arbiter: vector table for rotation/skip, hand sequences for stall,
// discard, asynchronous reset and counter wrap (4-bit counter).
module tb_dtn_arbiter;

  localparam int NS = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NS-1:0]  src_valid = '0;
  logic [NS*AW-1:0] src_from;
  logic [NS*AW-1:0] src_to;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]  src_ack;
  logic           dtn_valid;
  logic [AW-1:0]  dtn_from;
  logic [AW-1:0]  dtn_to;
  logic [DW-1:0]  dtn_data;
  logic           dtn_ack = 1'b0;
  logic [CW-1:0]  fwd_count;

  int n_checks = 0;
  int n_errors = 0;

  dtn_arbiter #(.NUM_SOURCES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_from(src_from), .src_to(src_to), .src_data(src_data),
    .src_ack(src_ack),
    .dtn_valid(dtn_valid), .dtn_from(dtn_from), .dtn_to(dtn_to), .dtn_data(dtn_data),
    .dtn_ack(dtn_ack), .fwd_count(fwd_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NS-1:0] valid;
    logic          dack;
    logic [NS-1:0] exp_ack;
    logic          exp_dv;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change #1 after a rising edge; checks happen #2 after it.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < NS; i++) begin
      src_from[i*AW +: AW] = AW'(i);
      src_to[i*AW +: AW]   = AW'(8'h10 + i);
      src_data[i*DW +: DW] = 32'hA000_0000 + i;
    end
  endtask

  initial begin
    set_defaults();
    // rotation with all sources valid, then only 1 and 3 valid (last=1 at entry 6)
    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 32'h0,         4'd0};
    vecs[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA000_0000, 4'd0};
    vecs[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA000_0001, 4'd1};
    vecs[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA000_0002, 4'd2};
    vecs[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA000_0003, 4'd3};
    vecs[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA000_0000, 4'd4};
    vecs[6] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 32'hA000_0001, 4'd5};
    vecs[7] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'hA000_0003, 4'd6};
    vecs[8] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 32'hA000_0001, 4'd7};

    // reset held with sources valid: nothing granted
    src_valid = 4'b1111;
    dtn_ack   = 1'b1;
    next_cycle();
    #1;
    check("rst_ack", 32'(src_ack), 32'h0);
    check("rst_valid", 32'(dtn_valid), 32'h0);
    check("rst_count", 32'(fwd_count), 32'h0);
    check("rst_data", dtn_data, 32'h0);
    next_cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      src_valid = vecs[i].valid;
      dtn_ack   = vecs[i].dack;
      #1;
      check($sformatf("vec%0d_ack", i), 32'(src_ack), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_valid", i), 32'(dtn_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) check($sformatf("vec%0d_data", i), dtn_data, vecs[i].exp_data);
      check($sformatf("vec%0d_count", i), 32'(fwd_count), 32'(vecs[i].exp_cnt));
      next_cycle();
    end

    // backpressure: slot holds src3 msg, last=3, count=8
    src_to[2*AW +: AW]   = 8'h05;
    src_data[2*DW +: DW] = 32'hDEAD_BEEF;
    src_valid = 4'b0100;
    dtn_ack   = 1'b1;
    #1;
    check("bp_load_ack", 32'(src_ack), 32'h4);
    next_cycle();
    src_valid = 4'b1111;
    dtn_ack   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_hold%0d_ack", c), 32'(src_ack), 32'h0);
      check($sformatf("bp_hold%0d_to", c), 32'(dtn_to), 32'h05);
      check($sformatf("bp_hold%0d_data", c), dtn_data, 32'hDEAD_BEEF);
      check($sformatf("bp_hold%0d_from", c), 32'(dtn_from), 32'h2);
      next_cycle();
    end
    check("bp_count_held", 32'(fwd_count), 32'd9);
    dtn_ack = 1'b1;
    #1;
    check("bp_release_ack", 32'(src_ack), 32'h8);
    next_cycle();
    check("bp_next_to", 32'(dtn_to), 32'h13);
    check("bp_next_data", dtn_data, 32'hA000_0003);
    check("bp_count", 32'(fwd_count), 32'd10);
    set_defaults();

    // drain, then discard from source 1
    src_valid = '0;
    next_cycle();
    check("drain_valid", 32'(dtn_valid), 32'h0);
    check("drain_count", 32'(fwd_count), 32'd11);
    src_to[1*AW +: AW] = 8'hFF;
    src_valid = 4'b0010;
    dtn_ack   = 1'b0;
    #1;
    check("disc_ack", 32'(src_ack), 32'h2);
    next_cycle();
    src_valid = '0;
    #1;
    check("disc_valid", 32'(dtn_valid), 32'h0);
    check("disc_count", 32'(fwd_count), 32'd11);
    set_defaults();

    // discard offered while full and stalled is not acked
    src_valid = 4'b0001;
    next_cycle();
    check("stall_fill_valid", 32'(dtn_valid), 32'h1);
    src_to[1*AW +: AW] = 8'hFF;
    src_valid = 4'b0010;
    #1;
    check("stall_disc_ack", 32'(src_ack), 32'h0);
    set_defaults();

    // asynchronous reset mid-stream with the slot full
    src_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(dtn_valid), 32'h0);
    check("async_rst_count", 32'(fwd_count), 32'h0);
    check("async_rst_ack", 32'(src_ack), 32'h0);
    next_cycle();
    reset_n = 1'b1;
    dtn_ack = 1'b1;
    #1;
    check("post_rst_first_ack", 32'(src_ack), 32'h1);

    // 17 forwarded messages wrap the 4-bit counter to 1
    for (int c = 0; c < 17; c++) next_cycle();
    check("wrap_count16", 32'(fwd_count), 32'h0);
    next_cycle();
    check("wrap_count17", 32'(fwd_count), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
